// File: rtl/rv_pkg.sv
// Shared writeback-stage types and constants: result select encoding,
// load size masks, the default load timeout and the load-wait FSM encoding.
package rv_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_IMM  = 2'b11
    } reg_write_src_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    localparam int unsigned LOAD_TIMEOUT_DEFAULT = 255;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half/word addressed by the low address
// bits out of the read word and zero- or sign-extends it to 32 bits.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  mask_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    // Halfwords are taken on 16-bit boundaries; offset bit 0 is don't-care.
    assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (mask_i)
            MASK_BYTE: data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            MASK_HALF: data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load-response wait with timeout fault,
// register-file write port generation and retirement counting.
module wb_stage
    import rv_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = LOAD_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_reg_write_src,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_pc_plus4,
    input  logic [31:0] mem_imm,
    input  logic        mem_mem_read,
    input  logic [3:0]  mem_data_mask,
    input  logic        mem_read_sign_extend,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg_write_rd,
    output logic [31:0] wb_reg_write_data,
    output logic        wb_stall,
    output logic        wb_retire,
    output logic        wb_load_fault,
    output logic [31:0] wb_retire_count
);

    // state   | meaning
    // IDLE    | no load outstanding, or load answered in its first cycle
    // WAIT    | load outstanding, counting cycles toward timeout

    // The IDLE detect cycle is the first wait cycle, so the WAIT counter
    // (cleared on entry) terminates one short of LOAD_TIMEOUT.
    localparam logic [31:0] TIMEOUT_TC = 32'(LOAD_TIMEOUT - 1);

    logic           valid_q;
    logic           reg_write_q;
    logic [4:0]     rd_q;
    reg_write_src_e src_q;
    logic [31:0]    alu_q;
    logic [31:0]    pc4_q;
    logic [31:0]    imm_q;
    logic           mem_read_q;
    logic [3:0]     mask_q;
    logic           sext_q;

    logic [0:0]     state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    retire_cnt_q, retire_cnt_d;

    logic           load_wait;
    logic           timeout_hit;
    logic           completing;
    logic [31:0]    load_data;
    logic [31:0]    result;

    load_align u_load_align (
        .rdata_i    (dmem_rdata),
        .offset_i   (alu_q[1:0]),
        .mask_i     (mask_q),
        .sign_ext_i (sext_q),
        .data_o     (load_data)
    );

    assign load_wait   = valid_q & mem_read_q & ~dmem_rvalid;
    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_TC);
    assign completing  = valid_q & ~load_wait;

    assign wb_stall      = load_wait & ~timeout_hit;
    assign wb_load_fault = load_wait & timeout_hit;
    assign wb_retire     = completing;
    assign wb_reg_write  = completing & reg_write_q & (rd_q != 5'd0);

    always_comb begin
        case (src_q)
            SRC_ALU:  result = alu_q;
            SRC_LOAD: result = load_data;
            SRC_PC4:  result = pc4_q;
            default:  result = imm_q;
        endcase
    end

    assign wb_reg_write_rd   = wb_reg_write ? rd_q : 5'd0;
    assign wb_reg_write_data = wb_reg_write ? result : 32'd0;
    assign wb_retire_count   = retire_cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_wait) begin
                    state_d = ST_WAIT;
                    cnt_d   = 32'd0;
                end
            end
            ST_WAIT: begin
                if (!load_wait || timeout_hit) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    assign retire_cnt_d = completing ? retire_cnt_q + 32'd1 : retire_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            src_q       <= SRC_ALU;
            alu_q       <= 32'd0;
            pc4_q       <= 32'd0;
            imm_q       <= 32'd0;
            mem_read_q  <= 1'b0;
            mask_q      <= MASK_WORD;
            sext_q      <= 1'b0;
        end else if (!wb_stall) begin
            valid_q     <= mem_valid;
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd;
            src_q       <= reg_write_src_e'(mem_reg_write_src);
            alu_q       <= mem_alu_result;
            pc4_q       <= mem_pc_plus4;
            imm_q       <= mem_imm;
            mem_read_q  <= mem_mem_read;
            mask_q      <= mem_data_mask;
            sext_q      <= mem_read_sign_extend;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for single-cycle completions
// plus hand sequences for delayed loads, timeout and reset during a wait.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_reg_write_src;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_imm;
    logic        mem_mem_read;
    logic [3:0]  mem_data_mask;
    logic        mem_read_sign_extend;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_write_rd;
    logic [31:0] wb_reg_write_data;
    logic        wb_stall, wb_retire, wb_load_fault;
    logic [31:0] wb_retire_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_count = 32'd0;

    wb_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .mem_valid            (mem_valid),
        .mem_reg_write        (mem_reg_write),
        .mem_rd               (mem_rd),
        .mem_reg_write_src    (mem_reg_write_src),
        .mem_alu_result       (mem_alu_result),
        .mem_pc_plus4         (mem_pc_plus4),
        .mem_imm              (mem_imm),
        .mem_mem_read         (mem_mem_read),
        .mem_data_mask        (mem_data_mask),
        .mem_read_sign_extend (mem_read_sign_extend),
        .dmem_rvalid          (dmem_rvalid),
        .dmem_rdata           (dmem_rdata),
        .wb_reg_write         (wb_reg_write),
        .wb_reg_write_rd      (wb_reg_write_rd),
        .wb_reg_write_data    (wb_reg_write_data),
        .wb_stall             (wb_stall),
        .wb_retire            (wb_retire),
        .wb_load_fault        (wb_load_fault),
        .wb_retire_count      (wb_retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        rd_en;
        logic [3:0]  mask;
        logic        sext;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_ret;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic valid, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic rd_en, input logic [3:0] mask, input logic sext,
                       input logic rvalid, input logic [31:0] rdata,
                       input logic exp_we, input logic [4:0] exp_rd,
                       input logic [31:0] exp_data, input logic exp_ret);
        vec_t v;
        v.valid = valid; v.rw = rw; v.rd = rd; v.src = src;
        v.alu = alu; v.pc4 = pc4; v.imm = imm;
        v.rd_en = rd_en; v.mask = mask; v.sext = sext;
        v.rvalid = rvalid; v.rdata = rdata;
        v.exp_we = exp_we; v.exp_rd = exp_rd; v.exp_data = exp_data; v.exp_ret = exp_ret;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0;
        mem_reg_write_src = 2'b00; mem_alu_result = 32'd0;
        mem_pc_plus4 = 32'd0; mem_imm = 32'd0; mem_mem_read = 1'b0;
        mem_data_mask = 4'b1111; mem_read_sign_extend = 1'b0;
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] alu,
                              input logic [3:0] mask, input logic sext);
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = rd;
        mem_reg_write_src = 2'b01; mem_alu_result = alu;
        mem_mem_read = 1'b1; mem_data_mask = mask; mem_read_sign_extend = sext;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".we"},    32'(wb_reg_write), 32'd0);
        chk({tag, ".rd"},    32'(wb_reg_write_rd), 32'd0);
        chk({tag, ".data"},  wb_reg_write_data, 32'd0);
        chk({tag, ".ret"},   32'(wb_retire), 32'd0);
        chk({tag, ".fault"}, 32'(wb_load_fault), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset.stall", 32'(wb_stall), 32'd0);
        chk("reset.count", wb_retire_count, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        //   valid rw rd  src alu           pc4           imm           rd_en mask  sext rv   rdata         we  rd  data          ret
        add(1, 1, 5'd5,  2'b00, 32'h00001234, 32'h0, 32'h0, 0, 4'hF, 0, 0, 32'h0,        1, 5'd5,  32'h00001234, 1);
        add(1, 1, 5'd0,  2'b10, 32'h0,        32'h104, 32'h0, 0, 4'hF, 0, 0, 32'h0,      0, 5'd0,  32'h0,        1);
        add(1, 1, 5'd7,  2'b01, 32'h00001002, 32'h0, 32'h0, 1, 4'h3, 0, 1, 32'hBEEF1234, 1, 5'd7,  32'h0000BEEF, 1);
        add(1, 1, 5'd31, 2'b11, 32'h77,       32'h88, 32'hDEADBEEF, 0, 4'hF, 0, 1, 32'hFFFFFFFF, 1, 5'd31, 32'hDEADBEEF, 1);
        add(1, 1, 5'd1,  2'b10, 32'h11,       32'h200, 32'h22, 0, 4'hF, 0, 0, 32'h0,     1, 5'd1,  32'h00000200, 1);
        add(1, 0, 5'd3,  2'b00, 32'hCAFE,     32'h0, 32'h0, 0, 4'hF, 0, 0, 32'h0,        0, 5'd0,  32'h0,        1);
        add(1, 1, 5'd8,  2'b01, 32'h00001001, 32'h0, 32'h0, 1, 4'h1, 1, 1, 32'h12348056, 1, 5'd8,  32'hFFFFFF80, 1);
        add(1, 1, 5'd9,  2'b01, 32'h3,        32'h0, 32'h0, 1, 4'h1, 0, 1, 32'hA5000000, 1, 5'd9,  32'h000000A5, 1);
        add(1, 1, 5'd10, 2'b01, 32'h7,        32'h0, 32'h0, 1, 4'h3, 1, 1, 32'h8001FFFF, 1, 5'd10, 32'hFFFF8001, 1);
        add(1, 1, 5'd11, 2'b01, 32'h0,        32'h0, 32'h0, 1, 4'h3, 1, 1, 32'h00007FFF, 1, 5'd11, 32'h00007FFF, 1);
        add(1, 1, 5'd12, 2'b01, 32'h2,        32'h0, 32'h0, 1, 4'hF, 1, 1, 32'h89ABCDEF, 1, 5'd12, 32'h89ABCDEF, 1);
        add(1, 1, 5'd0,  2'b01, 32'h0,        32'h0, 32'h0, 1, 4'hF, 0, 1, 32'h12345678, 0, 5'd0,  32'h0,        1);
        add(0, 1, 5'd9,  2'b00, 32'h99,       32'h0, 32'h0, 0, 4'hF, 0, 1, 32'h0,        0, 5'd0,  32'h0,        0);
        add(1, 1, 5'd13, 2'b01, 32'h100,      32'h0, 32'h0, 1, 4'h1, 1, 1, 32'hFFFFFF7F, 1, 5'd13, 32'h0000007F, 1);

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            string tag;
            v = vq[i];
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            mem_valid = v.valid; mem_reg_write = v.rw; mem_rd = v.rd;
            mem_reg_write_src = v.src; mem_alu_result = v.alu;
            mem_pc_plus4 = v.pc4; mem_imm = v.imm; mem_mem_read = v.rd_en;
            mem_data_mask = v.mask; mem_read_sign_extend = v.sext;
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            dmem_rvalid = v.rvalid;
            dmem_rdata = v.rdata;
            @(negedge clk);
            chk({tag, ".we"},    32'(wb_reg_write), 32'(v.exp_we));
            chk({tag, ".rd"},    32'(wb_reg_write_rd), 32'(v.exp_rd));
            chk({tag, ".data"},  wb_reg_write_data, v.exp_data);
            chk({tag, ".ret"},   32'(wb_retire), 32'(v.exp_ret));
            chk({tag, ".stall"}, 32'(wb_stall), 32'd0);
            chk({tag, ".fault"}, 32'(wb_load_fault), 32'd0);
            if (v.exp_ret) exp_count = exp_count + 32'd1;
            @(posedge clk);
            #1;
            dmem_rvalid = 1'b0;
            chk({tag, ".count"}, wb_retire_count, exp_count);
        end

        // Delayed signed byte load, with the next instruction held upstream during the stall.
        idle_inputs();
        @(negedge clk);
        drive_load(5'd10, 32'h00000002, 4'b0001, 1'b1);
        @(posedge clk);
        #1;
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd12;
        mem_reg_write_src = 2'b00; mem_alu_result = 32'h00000055;
        mem_mem_read = 1'b0; mem_data_mask = 4'b1111; mem_read_sign_extend = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("dly.stall%0d", c), 32'(wb_stall), 32'd1);
            chk_quiet($sformatf("dly.wait%0d", c));
            @(posedge clk);
        end
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h0080FF00;
        @(negedge clk);
        chk("dly.stall_rel", 32'(wb_stall), 32'd0);
        chk("dly.we",   32'(wb_reg_write), 32'd1);
        chk("dly.rd",   32'(wb_reg_write_rd), 32'd10);
        chk("dly.data", wb_reg_write_data, 32'hFFFFFF80);
        chk("dly.ret",  32'(wb_retire), 32'd1);
        exp_count = exp_count + 32'd1;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("held.we",   32'(wb_reg_write), 32'd1);
        chk("held.rd",   32'(wb_reg_write_rd), 32'd12);
        chk("held.data", wb_reg_write_data, 32'h00000055);
        exp_count = exp_count + 32'd1;
        @(posedge clk);
        #1;
        chk("held.count", wb_retire_count, exp_count);

        // Load that never gets a response: four stall cycles then a fault pulse.
        idle_inputs();
        @(negedge clk);
        drive_load(5'd4, 32'h0, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("to.stall%0d", c), 32'(wb_stall), 32'd1);
            chk_quiet($sformatf("to.wait%0d", c));
        end
        @(negedge clk);
        chk("to.stall_rel", 32'(wb_stall), 32'd0);
        chk("to.fault", 32'(wb_load_fault), 32'd1);
        chk("to.we",    32'(wb_reg_write), 32'd0);
        chk("to.ret",   32'(wb_retire), 32'd0);
        @(negedge clk);
        chk("to.fault_pulse", 32'(wb_load_fault), 32'd0);
        chk("to.stall_after", 32'(wb_stall), 32'd0);
        chk("to.count", wb_retire_count, exp_count);

        // Reset while waiting on a load; the late response must be ignored.
        @(negedge clk);
        drive_load(5'd6, 32'h0, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("rw.stall", 32'(wb_stall), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_quiet("rw.inreset");
        chk("rw.inreset.stall", 32'(wb_stall), 32'd0);
        chk("rw.inreset.count", wb_retire_count, 32'd0);
        exp_count = 32'd0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h0000FFFF;
        @(negedge clk);
        chk_quiet("rw.late");
        chk("rw.late.stall", 32'(wb_stall), 32'd0);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        chk("rw.count", wb_retire_count, 32'd0);
        @(negedge clk);
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd2;
        mem_reg_write_src = 2'b00; mem_alu_result = 32'h00000042; mem_mem_read = 1'b0;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("post.we",    32'(wb_reg_write), 32'd1);
        chk("post.data",  wb_reg_write_data, 32'h00000042);
        chk("post.stall", 32'(wb_stall), 32'd0);
        exp_count = exp_count + 32'd1;
        @(posedge clk);
        #1;
        chk("post.count", wb_retire_count, exp_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
